min_window_stats: RTL and testbench
===================================

# min_window_stats

Downstream consumer of the three-input registered minimum tree, which has 2-cycle latency from a/b/c to d. Takes the tree's 8-bit result d plus the valid that accompanied the a/b/c triple. Delays that valid internally to line up with d, then reduces every WIN aligned samples to one window summary: minimum, maximum, window index and threshold alarm. The summary is delivered with a one-cycle out_valid pulse.

## Interface
- WIDTH, 8, sample width; must match d of the min tree
- WIN, 16, samples per window; legal range 2..255
- THRESH, 8'd16, alarm when window minimum is strictly below this value
- clk  input  1  clock; all state on posedge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  high in the same cycle the min tree samples a/b/c
- d  input  WIDTH  min-tree output; meaningful 2 cycles after in_valid
- clear  input  1  synchronous abort of the current window
- out_valid  output  1  one-cycle pulse, window summary updated
- win_min  output  WIDTH  minimum of the last completed window
- win_max  output  WIDTH  maximum of the last completed window
- win_idx  output  8  count of completed windows, mod 256
- alarm  output  1  win_min < THRESH for the last completed window

## Operation
- Valid alignment: 2-stage shift register v1 <= in_valid, v2 <= v1. A sample is accepted when v2=1 and clear=0; the accepted value is d in that cycle.
- State: cnt (8-bit, 0..WIN-1) plus accumulators acc_min and acc_max.
- FSM:
  - EMPTY (cnt=0): an accepted sample loads acc_min=acc_max=d, sets cnt=1 and moves to ACCUM.
  - ACCUM: an accepted sample updates acc_min=min(acc_min,d) and acc_max=max(acc_max,d), then cnt+1.
  - When a sample is accepted with cnt=WIN-1, the next cycle gives:
    - win_min/win_max = final accumulators including that sample
    - alarm = (final min < THRESH)
    - win_idx+1 (255 wraps to 0)
    - out_valid=1
    - cnt=0, state EMPTY
- Comparisons are unsigned. Ties keep the stored value; the result is identical either way.
- win_min, win_max, win_idx and alarm hold between emissions.
- clear=1:
  - cnt=0, state EMPTY, v1=v2=0.
  - Accumulators are don't-care.
  - The summary outputs and win_idx hold.
  - out_valid=0 in the following cycle.
- clear coinciding with the WIN-th aligned sample: clear wins. No emission, win_idx unchanged.
- clear asserted with in_valid=1: that triple's valid is discarded, because v1 is cleared.
- Gaps in in_valid are allowed anywhere. The window spans WIN accepted samples, not WIN cycles.
- Back-to-back windows: with continuous in_valid, the first sample of window k+1 is accepted in the same cycle that window k's out_valid is high.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0, win_min=0, win_max=0, win_idx=0, alarm=0
  - cnt=0, v1=v2=0, state EMPTY
- Release of rst_n is synchronous to clk. The first in_valid can be sampled on the first posedge after release.
- Latency: in_valid of the WIN-th triple at cycle T gives d at T+2, then out_valid and the new summary at T+3.
- out_valid is never high two consecutive cycles, since WIN>=2.
- Reset asserted mid-window discards the partial window. Reset in the out_valid cycle clears all outputs immediately.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset check: rst_n low, then in_valid=1 for 2 cycles -> all outputs 0 during reset. No out_valid until WIN aligned samples.
- WIN=4, d sequence 40, 12, 90, 33 aligned to valid -> out_valid exactly 3 cycles after the 4th in_valid, with win_min=12, win_max=90, win_idx=1, alarm=1.
- WIN=4, continuous in_valid, d 20, 25, 30, 35, 200, 17, 18, 19:
  - two pulses 4 cycles apart
  - first: min 20, max 35, alarm 0
  - second: min 17, max 200, alarm 0
  - win_idx goes 1 then 2
- Gapped valid (one idle cycle between each sample), WIN=4 -> emission only after 4 accepted samples. Summary outputs hold unchanged during gaps.
- clear in the same cycle as the 4th aligned sample -> no out_valid, win_idx unchanged. The next 4 samples give one emission with values from those 4 only.
- 256 windows of constant d=0xFF -> win_idx wraps 255 to 0. Every window gives win_min=win_max=0xFF and alarm=0.

Source files
------------

// File: rtl/min_window_stats_if.sv
// Sample/summary bundle between the min-tree consumer and its environment.
// The master drives samples and clear. The slave (min_window_stats) returns window summaries.
interface min_window_stats_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] win_min;
  logic [WIDTH-1:0] win_max;
  logic [7:0]       win_idx;
  logic             alarm;

  modport master (
    output in_valid, d, clear,
    input  out_valid, win_min, win_max, win_idx, alarm
  );

  modport slave (
    input  in_valid, d, clear,
    output out_valid, win_min, win_max, win_idx, alarm
  );
endinterface

// File: rtl/min_window_stats.sv
// Windowed min/max/alarm reducer placed behind the 2-cycle three-input min tree.
// Every WIN accepted samples produce one registered summary with a single-cycle out_valid pulse.
module min_window_stats #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      WIN    = 16,
  parameter logic [WIDTH-1:0] THRESH = WIDTH'(16)
) (
  input logic               clk,
  input logic               rst_n,
  min_window_stats_if.slave bus_io
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;
  localparam logic [7:0] LastCnt = 8'(WIN - 1);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [0:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] win_min_q, win_min_d, win_max_q, win_max_d;
  logic [7:0]       win_idx_q, win_idx_d;
  logic             alarm_q, alarm_d;
  logic             accept;
  logic [WIDTH-1:0] nxt_min, nxt_max;

  always_comb begin
    accept = v2_q & ~bus_io.clear;

    // The first sample of a window seeds both accumulators.
    if (state_q == StEmpty) begin
      nxt_min = bus_io.d;
      nxt_max = bus_io.d;
    end else begin
      nxt_min = (bus_io.d < acc_min_q) ? bus_io.d : acc_min_q;
      nxt_max = (bus_io.d > acc_max_q) ? bus_io.d : acc_max_q;
    end

    v1_d        = bus_io.in_valid & ~bus_io.clear;
    v2_d        = v1_q & ~bus_io.clear;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    out_valid_d = 1'b0;
    win_min_d   = win_min_q;
    win_max_d   = win_max_q;
    win_idx_d   = win_idx_q;
    alarm_d     = alarm_q;

    if (bus_io.clear) begin
      cnt_d   = 8'd0;
      state_d = StEmpty;
    end else if (accept) begin
      acc_min_d = nxt_min;
      acc_max_d = nxt_max;
      if (cnt_q == LastCnt) begin
        cnt_d       = 8'd0;
        state_d     = StEmpty;
        out_valid_d = 1'b1;
        win_min_d   = nxt_min;
        win_max_d   = nxt_max;
        win_idx_d   = win_idx_q + 8'd1;
        alarm_d     = (nxt_min < THRESH);
      end else begin
        cnt_d   = cnt_q + 8'd1;
        state_d = StAccum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      state_q     <= StEmpty;
      cnt_q       <= 8'd0;
      acc_min_q   <= '0;
      acc_max_q   <= '0;
      out_valid_q <= 1'b0;
      win_min_q   <= '0;
      win_max_q   <= '0;
      win_idx_q   <= 8'd0;
      alarm_q     <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      out_valid_q <= out_valid_d;
      win_min_q   <= win_min_d;
      win_max_q   <= win_max_d;
      win_idx_q   <= win_idx_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.win_min   = win_min_q;
  assign bus_io.win_max   = win_max_q;
  assign bus_io.win_idx   = win_idx_q;
  assign bus_io.alarm     = alarm_q;

endmodule

// File: tb/tb_min_window_stats.sv
// Scoreboard bench for min_window_stats: the stimulus side predicts summaries from window contents,
// and an independent monitor checks every out_valid pulse and the holding of outputs between pulses.
module tb_min_window_stats;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WIN    = 4;
  localparam logic [7:0]  THRESH = 8'd16;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  idx;
    logic        al;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  min_window_stats_if #(.WIDTH(WIDTH)) bus ();

  min_window_stats #(
    .WIDTH (WIDTH),
    .WIN   (WIN),
    .THRESH(THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned edge_n = 0;
  exp_t        exp_q[$];

  // Reference-model state: the triples of the last two steps and the current window contents.
  logic        pv[2];
  logic [7:0]  pval[2];
  logic        pc[2];
  logic [7:0]  win_q[$];
  logic [7:0]  m_idx = 8'd0;

  logic [7:0]  last_min = 8'd0;
  logic [7:0]  last_max = 8'd0;
  logic [7:0]  last_idx = 8'd0;
  logic        last_al  = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock step: the triple is issued now, and d carries the triple issued two steps earlier.
  // A triple is accepted only if clear is low in its own step and in the two steps after it.
  task automatic step(input logic v, input logic [7:0] val, input logic clr);
    logic [7:0] mn, mx;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.clear    = clr;
    bus.d        = pv[1] ? pval[1] : 8'($urandom);
    if (clr) begin
      win_q.delete();
    end else if (pv[1] && !pc[1] && !pc[0]) begin
      win_q.push_back(pval[1]);
      if (win_q.size() == WIN) begin
        mn = 8'hFF;
        mx = 8'h00;
        foreach (win_q[i]) begin
          if (win_q[i] < mn) mn = win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
        end
        m_idx = m_idx + 8'd1;
        exp_q.push_back('{edge_n + 1, mn, mx, m_idx, (mn < THRESH)});
        win_q.delete();
      end
    end
    pv[1] = pv[0];  pval[1] = pval[0];  pc[1] = pc[0];
    pv[0] = v;      pval[0] = val;      pc[0] = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        chk("missed_pulse_cycle", edge_n, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", edge_n, e.cyc);
          chk("win_min", 32'(bus.win_min), 32'(e.mn));
          chk("win_max", 32'(bus.win_max), 32'(e.mx));
          chk("win_idx", 32'(bus.win_idx), 32'(e.idx));
          chk("alarm", 32'(bus.alarm), 32'(e.al));
          last_min = e.mn;
          last_max = e.mx;
          last_idx = e.idx;
          last_al  = e.al;
        end
      end else begin
        chk("hold_summary", {7'd0, bus.win_min, bus.win_max, bus.win_idx, bus.alarm},
            {7'd0, last_min, last_max, last_idx, last_al});
      end
    end
  end

  initial begin
    logic [7:0] p1[4];
    logic [7:0] p2[8];
    logic [7:0] idx_before;
    p1 = '{8'd40, 8'd12, 8'd90, 8'd33};
    p2 = '{8'd20, 8'd25, 8'd30, 8'd35, 8'd200, 8'd17, 8'd18, 8'd19};
    pv   = '{1'b0, 1'b0};
    pval = '{8'd0, 8'd0};
    pc   = '{1'b0, 1'b0};

    // Reset with in_valid toggling must leave every output at zero.
    bus.in_valid = 1'b1;
    bus.d        = 8'h55;
    bus.clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_win_min", 32'(bus.win_min), 32'd0);
    chk("rst_win_max", 32'(bus.win_max), 32'd0);
    chk("rst_win_idx", 32'(bus.win_idx), 32'd0);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    idle(3);

    // Single window with a low minimum.
    foreach (p1[i]) step(1'b1, p1[i], 1'b0);
    idle(4);
    chk("p1_min", 32'(bus.win_min), 32'd12);
    chk("p1_max", 32'(bus.win_max), 32'd90);
    chk("p1_idx", 32'(bus.win_idx), 32'd1);
    chk("p1_alarm", 32'(bus.alarm), 32'd1);

    // Back-to-back windows under continuous valid.
    foreach (p2[i]) step(1'b1, p2[i], 1'b0);
    idle(4);
    chk("p2_min", 32'(bus.win_min), 32'd17);
    chk("p2_max", 32'(bus.win_max), 32'd200);
    chk("p2_idx", 32'(bus.win_idx), 32'd3);

    // One idle cycle between samples.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(60 + 10 * i), 1'b0);
      idle(1);
    end
    idle(3);
    chk("gap_min", 32'(bus.win_min), 32'd60);
    chk("gap_max", 32'(bus.win_max), 32'd90);

    // Clear lands on the 4th aligned sample; the following window stands alone.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(5 + i), 1'b0);
    idle(1);
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(100 + i), 1'b0);
    idle(4);
    chk("clr_min", 32'(bus.win_min), 32'd100);
    chk("clr_max", 32'(bus.win_max), 32'd103);
    chk("clr_idx", 32'(bus.win_idx), 32'd5);
    chk("clr_alarm", 32'(bus.alarm), 32'd0);

    // Random valid/data/clear mix.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0);
    idle(4);

    // 256 windows of 0xFF bring win_idx all the way round.
    idx_before = m_idx;
    for (int i = 0; i < 256 * WIN; i++) step(1'b1, 8'hFF, 1'b0);
    idle(4);
    chk("wrap_idx", 32'(bus.win_idx), 32'(idx_before));
    chk("wrap_min", 32'(bus.win_min), 32'hFF);
    chk("wrap_alarm", 32'(bus.alarm), 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
